hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage RISC-V core; companion to the forwarding unit.
//  Resolves what forwarding cannot: load-use stalls, taken-branch flushes and multi-cycle MUL/DIV
//  occupancy of Execute. Drives the stall/flush enables of the F/D, D/E and E/M pipeline registers.
// PARAMETERS
//  MD_LATENCY  4   cycles a MUL/DIV op occupies Execute, including its issue cycle; legal range 2..255
//  CNT_W       16  width of the saturating stall-cycle performance counter
// PORTS
//  clk          in   1      pipeline clock
//  reset        in   1      asynchronous, active-high reset
//  RS1D         in   5      rs1 of the instruction in Decode
//  RS2D         in   5      rs2 of the instruction in Decode
//  RDE          in   5      rd of the instruction in Execute
//  ResultSrcE0  in   1      instruction in Execute is a load
//  PCSrcE       in   1      branch or jump taken in Execute
//  MdStartE     in   1      instruction in Execute is a multi-cycle MUL/DIV
//  StallF       out  1      hold the PC register
//  StallD       out  1      hold the F/D register
//  StallE       out  1      hold the D/E register
//  FlushD       out  1      clear the F/D register (insert bubble)
//  FlushE       out  1      clear the D/E register
//  FlushM       out  1      clear the E/M register
//  MdBusy       out  1      MUL/DIV sequence in progress (registered state != RUN)
//  MdDoneE      out  1      one-cycle pulse: MUL/DIV result valid in Execute this cycle
//  StallCount   out  CNT_W  count of cycles with StallF=1, saturating at all-ones
// BEHAVIOUR
//  - FSM states: RUN, MD_BUSY. Down-counter mdCnt is 8 bits. Outputs are Mealy: f(state, inputs).
//  - Reset (async): state=RUN, mdCnt=0, StallCount=0. Every output is 0 while reset is high.
//    A reset asserted during MD_BUSY abandons the operation; no MdDoneE pulse is produced.
//  - lwStall = ResultSrcE0 & (RDE!=0) & (RDE==RS1D | RDE==RS2D). Evaluated only in RUN.
//  - Priority in RUN: PCSrcE > MdStartE > lwStall. The lower-priority event is ignored that cycle.
//  - RUN, PCSrcE=1: FlushD=1, FlushE=1; all stalls 0. Stay in RUN.
//  - RUN, lwStall=1: StallF=1, StallD=1, FlushE=1 for that cycle only. Stay in RUN. The hazard
//    clears on the next cycle because the load has moved to Memory.
//  - RUN, MdStartE=1 at cycle t: StallF=StallD=StallE=1 and FlushM=1. Next state is MD_BUSY with
//    mdCnt=MD_LATENCY-2.
//  - MD_BUSY: StallF=StallD=StallE=1 and FlushM=1. PCSrcE, MdStartE and lwStall are ignored.
//    mdCnt decrements each cycle. When mdCnt==0: MdDoneE=1, and the next state is RUN.
//  - Net timing: stalls are high in cycles t..t+MD_LATENCY-1 (exactly MD_LATENCY cycles).
//    MdDoneE is high in cycle t+MD_LATENCY-1. The pipeline advances at the t+MD_LATENCY edge.
//  - Back-to-back MUL/DIV: the first cycle back in RUN samples MdStartE of the next instruction.
//    A new sequence may start that cycle; there is no idle gap.
//  - MD_LATENCY=2: MD_BUSY lasts exactly one cycle (mdCnt loads 0).
//  - x0 destination never causes a stall. RS1D/RS2D are compared regardless of whether the
//    instruction actually reads them (conservative).
//  - StallCount increments on every clk edge where StallF=1. It holds at 2^CNT_W-1.
//  - MdBusy = (state==MD_BUSY). It is registered, so it goes high one cycle after t.
// TESTING
//  1. Load-use: ResultSrcE0=1, RDE=5, RS2D=5 -> single cycle StallF=StallD=FlushE=1; all 0 next cycle.
//  2. No false stall: ResultSrcE0=1, RDE=0, RS1D=0 -> no stall. RDE=5, RS1D=6, RS2D=7 -> no stall.
//  3. Branch: PCSrcE=1 together with MdStartE=1 -> FlushD=FlushE=1, no stall, MdBusy stays 0.
//  4. MUL/DIV, MD_LATENCY=4: MdStartE held high from t -> stalls and FlushM high for t..t+3,
//     MdDoneE only at t+3, MdBusy high t+1..t+3. Repeat back-to-back -> next stall window starts at t+4.
//  5. Reset mid-op: assert reset at t+1 of an MD sequence -> all outputs 0 immediately,
//     no MdDoneE, StallCount=0; after release, a lwStall behaves as in test 1.
//  6. Counter: CNT_W=4, hold a 20-cycle stall stream -> StallCount reaches 15 and holds at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline sequencing controller for the 5-stage RISC-V core. It handles
//   the hazards that forwarding cannot resolve:
//     - load-use: a one-cycle stall of Fetch/Decode plus a bubble into Execute
//     - taken branch/jump: flush of Decode and Execute
//     - multi-cycle MUL/DIV: Execute is held for MD_LATENCY cycles
//   It also keeps a saturating count of cycles in which Fetch is stalled.
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   RS1D, RS2D                 source registers of the instruction in Decode
//   RDE                        destination register of the instruction in Execute
//   ResultSrcE0                Execute holds a load
//   PCSrcE                     branch/jump taken in Execute
//   MdStartE                   Execute holds a multi-cycle MUL/DIV
//   StallF/StallD/StallE       hold the PC, F/D and D/E registers
//   FlushD/FlushE/FlushM       clear the F/D, D/E and E/M registers
//   MdBusy                     registered: MUL/DIV sequence in progress
//   MdDoneE                    one-cycle pulse: MUL/DIV result valid in Execute
//   StallCount                 saturating count of StallF cycles
module hazard_stall_ctrl #(
   parameter int MD_LATENCY = 4,   // 2..255, includes the issue cycle
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       RS1D,
   input  logic [4:0]       RS2D,
   input  logic [4:0]       RDE,
   input  logic             ResultSrcE0,
   input  logic             PCSrcE,
   input  logic             MdStartE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushM,
   output logic             MdBusy,
   output logic             MdDoneE,
   output logic [CNT_W-1:0] StallCount
);

   typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

   // The issue cycle is spent in RUN and the final cycle is the one where the
   // counter reads zero, so the counter loads MD_LATENCY-2.
   localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 2);

   state_t     state, state_nxt;
   logic [7:0] md_cnt, md_cnt_nxt;
   logic       lw_stall;

   // x0 is never a real destination, so it can never create a load-use hazard.
   assign lw_stall = ResultSrcE0 && (RDE != 5'd0) && ((RDE == RS1D) || (RDE == RS2D));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= RUN;
         md_cnt <= 8'd0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   // Next-state logic; a taken branch kills a MUL/DIV sitting behind it.
   always_comb begin
      state_nxt  = state;
      md_cnt_nxt = md_cnt;
      case (state)
         RUN: begin
            if (!PCSrcE && MdStartE) begin
               state_nxt  = MD_BUSY;
               md_cnt_nxt = MD_LOAD;
            end
         end
         MD_BUSY: begin
            if (md_cnt == 8'd0) state_nxt = RUN;
            else                md_cnt_nxt = md_cnt - 8'd1;
         end
         default: state_nxt = RUN;
      endcase
   end

   // Mealy outputs. Everything is forced low while reset is held, even though
   // the inputs may still be presenting a hazard.
   always_comb begin
      StallF  = 1'b0;
      StallD  = 1'b0;
      StallE  = 1'b0;
      FlushD  = 1'b0;
      FlushE  = 1'b0;
      FlushM  = 1'b0;
      MdBusy  = 1'b0;
      MdDoneE = 1'b0;
      if (!reset) begin
         case (state)
            RUN: begin
               if (PCSrcE) begin
                  FlushD = 1'b1;
                  FlushE = 1'b1;
               end else if (MdStartE) begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  StallE = 1'b1;
                  FlushM = 1'b1;   // E/M sees bubbles until the result is ready
               end else if (lw_stall) begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  FlushE = 1'b1;
               end
            end
            MD_BUSY: begin
               StallF  = 1'b1;
               StallD  = 1'b1;
               StallE  = 1'b1;
               FlushM  = ~(md_cnt == 8'd0) | 1'b1;
               MdBusy  = 1'b1;
               MdDoneE = (md_cnt == 8'd0);
            end
            default: ;
         endcase
      end
   end

   // Stall-cycle performance counter, saturating at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         StallCount <= '0;
      else if (StallF && (StallCount != {CNT_W{1'b1}}))
         StallCount <= StallCount + 1'b1;
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl (MD_LATENCY=4, CNT_W=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. Output vector order: {StallF,StallD,StallE,FlushD,FlushE,FlushM,MdBusy,MdDoneE}.
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] RS1D, RS2D, RDE;
   logic       ResultSrcE0, PCSrcE, MdStartE;
   logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdDoneE;
   logic [3:0] StallCount;

   int checks = 0;
   int errors = 0;

   localparam logic [7:0] NONE = 8'b0000_0000;
   localparam logic [7:0] LWS  = 8'b1100_1000;   // load-use stall
   localparam logic [7:0] BRF  = 8'b0001_1000;   // branch flush
   localparam logic [7:0] MDI  = 8'b1110_0100;   // MUL/DIV issue cycle
   localparam logic [7:0] MDB  = 8'b1110_0110;   // MUL/DIV busy
   localparam logic [7:0] MDD  = 8'b1110_0111;   // MUL/DIV done

   hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .RS1D(RS1D), .RS2D(RS2D), .RDE(RDE),
      .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
      .MdBusy(MdBusy), .MdDoneE(MdDoneE), .StallCount(StallCount)
   );

   always #5 clk = ~clk;

   task automatic chk_out(input string tag, input logic [7:0] exp);
      logic [7:0] obs;
      obs = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdDoneE};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [3:0] exp);
      checks++;
      assert (StallCount === exp) else begin
         errors++;
         $error("FAIL %s: StallCount observed %0d expected %0d", tag, StallCount, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle();
      RS1D = 5'd0; RS2D = 5'd0; RDE = 5'd0;
      ResultSrcE0 = 1'b0; PCSrcE = 1'b0; MdStartE = 1'b0;
   endtask

   task automatic loaduse();
      idle();
      ResultSrcE0 = 1'b1; RDE = 5'd5; RS1D = 5'd1; RS2D = 5'd5;
   endtask

   initial begin
      // Reset with a hazard present on the inputs: outputs must stay low.
      reset = 1'b1;
      loaduse();
      smp();
      chk_out("reset_outputs", NONE);
      chk_cnt("reset_count", 4'd0);
      nxt();
      reset = 1'b0;
      idle();

      // 1. Load-use on rs2
      nxt(); loaduse();
      smp(); chk_out("lw_rs2", LWS);
      nxt(); idle();
      smp(); chk_out("lw_clears", NONE);
      chk_cnt("lw_count", 4'd1);

      // 2. No false stalls; then a genuine rs1 match
      nxt(); ResultSrcE0 = 1'b1; RDE = 5'd0; RS1D = 5'd0;
      smp(); chk_out("x0_no_stall", NONE);
      nxt(); RDE = 5'd5; RS1D = 5'd6; RS2D = 5'd7;
      smp(); chk_out("nomatch_no_stall", NONE);
      nxt(); RDE = 5'd6;
      smp(); chk_out("lw_rs1", LWS);
      nxt(); ResultSrcE0 = 1'b0;
      smp(); chk_out("not_load_no_stall", NONE);

      // 3. Branch wins over MUL/DIV and load-use
      nxt(); loaduse(); PCSrcE = 1'b1; MdStartE = 1'b1;
      smp(); chk_out("branch_priority", BRF);
      nxt(); idle();
      smp(); chk_out("branch_no_md", NONE);
      chk_cnt("count_before_md", 4'd2);

      // 4. MUL/DIV back-to-back, PCSrcE ignored while busy
      nxt(); MdStartE = 1'b1;
      smp(); chk_out("md_t0", MDI);
      nxt(); smp(); chk_out("md_t1", MDB);
      nxt(); smp(); chk_out("md_t2", MDB);
      nxt(); smp(); chk_out("md_t3_done", MDD);
      nxt(); smp(); chk_out("md2_t4_issue", MDI);
      nxt(); PCSrcE = 1'b1;
      smp(); chk_out("md2_busy_ignores_branch", MDB);
      nxt(); PCSrcE = 1'b0;
      smp(); chk_out("md2_t6", MDB);
      nxt(); smp(); chk_out("md2_t7_done", MDD);
      nxt(); idle();
      smp(); chk_out("md_end", NONE);
      chk_cnt("count_after_md", 4'd10);

      // 5. Reset in the middle of a MUL/DIV sequence
      nxt(); MdStartE = 1'b1;
      smp(); chk_out("md_rst_t0", MDI);
      nxt(); idle();
      smp(); chk_out("md_rst_t1", MDB);
      #1 reset = 1'b1;
      #1 chk_out("md_rst_immediate", NONE);
      chk_cnt("md_rst_count", 4'd0);
      nxt(); smp(); chk_out("md_rst_no_done", NONE);
      nxt(); reset = 1'b0;
      smp(); chk_out("after_rst_idle", NONE);
      nxt(); loaduse();
      smp(); chk_out("after_rst_lw", LWS);
      nxt(); idle();
      smp(); chk_out("after_rst_lw_clear", NONE);
      chk_cnt("after_rst_count", 4'd1);

      // 6. Counter saturation over a 20-cycle stall stream
      nxt(); reset = 1'b1;
      nxt(); reset = 1'b0; loaduse();
      for (int k = 1; k <= 20; k++) begin
         nxt();
         if (k == 14) chk_cnt("sat_14", 4'd14);
         if (k == 15) chk_cnt("sat_15", 4'd15);
         if (k == 20) chk_cnt("sat_hold", 4'd15);
      end
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
